// File: rtl/atm_pkg.sv
// Shared definitions for the ATM controller: PIN-entry FSM states, keypad
// constants and the top-level controller state codes.
package atm_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_COLLECT,
        PS_CHECK,
        PS_DONE,
        PS_LOCKED
    } pin_state_t;

    // Top-level controller state codes shared with the next-state logic.
    localparam logic [2:0] ATM_ST_IDLE     = 3'b000;
    localparam logic [2:0] ATM_ST_PIN      = 3'b001;
    localparam logic [2:0] ATM_ST_MENU     = 3'b010;
    localparam logic [2:0] ATM_ST_WITHDRAW = 3'b011;
    localparam logic [2:0] ATM_ST_DEPOSIT  = 3'b100;
    localparam logic [2:0] ATM_ST_BALANCE  = 3'b101;
    localparam logic [2:0] ATM_ST_EJECT    = 3'b110;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return k <= DIGIT_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/atm_pin_shreg.sv
// Digit buffer for PIN entry: shifts accepted digits in at the LS nibble,
// counts them, flags a full entry and compares against the stored PIN.
module atm_pin_shreg
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          shift,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic [DIGIT_W*PIN_DIGITS-1:0] stored_pin,
    output logic                          full,
    output logic                          match
);

    localparam int BUF_W = DIGIT_W * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    logic [BUF_W-1:0] digit_buf;
    logic [CNT_W-1:0] digit_cnt;

    assign full  = (digit_cnt == CNT_W'(PIN_DIGITS));
    assign match = (digit_buf == stored_pin);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_buf <= '0;
            digit_cnt <= '0;
        end else if (clr) begin
            digit_buf <= '0;
            digit_cnt <= '0;
        end else if (shift && !full) begin
            digit_buf <= {digit_buf[BUF_W-DIGIT_W-1:0], digit};
            digit_cnt <= digit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/atm_pin_entry.sv
// PIN entry/verification stage: collects keypad digits, checks them against
// the card PIN, counts failures and locks. Optional idle timeout: ATM_PIN_TIMEOUT_EN.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          b,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key,
    input  logic [DIGIT_W*PIN_DIGITS-1:0] stored_pin,
    input  logic                          unlock,
    output logic                          e,
    output logic                          v,
    output logic                          lock,
    output logic [2:0]                    tries
);

    if (PIN_DIGITS < 2 || PIN_DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 7 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("atm_pin_entry: parameter out of range");
    end

    pin_state_t state;
    logic       cancel;
    logic       clr;
    logic       shift;
    logic       full;
    logic       match;
    logic       timeout;
    logic       force_fail;
    logic [2:0] tries_inc;

    assign cancel    = !start || b;
    assign clr       = (state == PS_IDLE && !cancel) ||
                       ((state == PS_COLLECT || state == PS_CHECK) && cancel);
    assign shift     = (state == PS_COLLECT) && !cancel && key_valid && is_digit(key);
    assign tries_inc = tries + 3'd1;

    atm_pin_shreg #(.PIN_DIGITS(PIN_DIGITS)) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift     (shift),
        .digit     (key),
        .stored_pin(stored_pin),
        .full      (full),
        .match     (match)
    );

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign timeout = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // force_fail is high exactly in the CHECK cycle reached through a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt    <= '0;
            force_fail <= 1'b0;
        end else begin
            force_fail <= (state == PS_COLLECT) && !cancel && !full && timeout;
            if (state != PS_COLLECT || shift) begin
                tmo_cnt <= '0;
            end else if (!timeout) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign timeout    = 1'b0;
    assign force_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PS_IDLE;
            e     <= 1'b0;
            v     <= 1'b0;
            lock  <= 1'b0;
            tries <= 3'd0;
        end else begin
            case (state)
                PS_IDLE: begin
                    e <= 1'b0;
                    v <= 1'b0;
                    if (!cancel) state <= PS_COLLECT;
                end
                PS_COLLECT: begin
                    if (cancel)       state <= PS_IDLE;
                    else if (full)    state <= PS_CHECK;
                    else if (timeout) state <= PS_CHECK;
                end
                PS_CHECK: begin
                    if (cancel) begin
                        state <= PS_IDLE;
                    end else if (match && !force_fail) begin
                        state <= PS_DONE;
                        e     <= 1'b1;
                        v     <= 1'b1;
                        tries <= 3'd0;
                    end else begin
                        tries <= tries_inc;
                        e     <= 1'b1;
                        v     <= 1'b0;
                        if (tries_inc == 3'(MAX_TRIES)) begin
                            state <= PS_LOCKED;
                            lock  <= 1'b1;
                        end else begin
                            state <= PS_DONE;
                        end
                    end
                end
                PS_DONE: begin
                    if (cancel) begin
                        state <= PS_IDLE;
                        e     <= 1'b0;
                        v     <= 1'b0;
                    end
                end
                PS_LOCKED: begin
                    if (unlock) begin
                        state <= PS_IDLE;
                        lock  <= 1'b0;
                        tries <= 3'd0;
                        e     <= 1'b0;
                        v     <= 1'b0;
                    end
                end
                default: state <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

PIN entry and verification stage of the ATM controller. It sits directly upstream of the next-state logic and produces the entry-complete flag E and the PIN-valid flag V that the next-state bits consume while the controller is in state 001. It collects keypad digits, compares them against the card's stored PIN, counts failed attempts and locks the card after too many failures.

## Interface
- PIN_DIGITS, 4, digits per PIN (2..8)
- MAX_TRIES, 3, failed attempts before lock (1..7)
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before forced failure (only with ATM_PIN_TIMEOUT_EN)
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  level; high while the controller is in PIN state (001)
- B  input  1  cancel button, level, sampled each cycle
- KEY_VALID  input  1  one-cycle strobe, KEY holds a keypress
- KEY  input  4  key code; 0..9 are digits, 10..15 are ignored
- STORED_PIN  input  4*PIN_DIGITS  card PIN, first digit in MS nibble, stable while START=1
- UNLOCK  input  1  operator unlock strobe
- E  output  1  entry complete (registered)
- V  output  1  PIN valid, meaningful only when E=1 (registered)
- LOCK  output  1  card locked (registered)
- TRIES  output  3  failed-attempt count (registered)

## Operation
- States: IDLE, COLLECT, CHECK, DONE, LOCKED.
- Reset values: state=IDLE, E=0, V=0, LOCK=0, TRIES=0, digit buffer=0, digit count=0.
- IDLE: E=V=0. If START=1 and B=0, go to COLLECT and clear the buffer and digit count.
- COLLECT: on KEY_VALID with KEY<=9, shift the digit into the LS nibble and increment the count. Keys 10..15 are dropped. When the accepted key is digit PIN_DIGITS, go to CHECK.
- CHECK: one cycle. Compare the whole buffer with STORED_PIN.
  - Match: go to DONE with V=1, TRIES=0.
  - Mismatch: TRIES+1. If the new TRIES equals MAX_TRIES, go to LOCKED; otherwise go to DONE with V=0.
- DONE: E=1, V=result. Hold until START=0 or B=1, then go to IDLE with E=V=0. KEY_VALID is ignored.
- LOCKED: LOCK=1, E=1, V=0. START, B and keys are ignored. UNLOCK goes to IDLE with LOCK=0 and TRIES=0.
- TRIES persists across START sessions. It clears only on a match, on UNLOCK, or on reset.
- Priority when events coincide: RST_N, then UNLOCK (LOCKED only), then START=0, then B, then KEY_VALID.
- Cancel (B=1 or START=0) in COLLECT or CHECK: go to IDLE, clear the buffer, TRIES unchanged, E stays 0.

## Timing
- Final digit accepted at edge n, CHECK at n+1, E/V/LOCK/TRIES valid after edge n+2.
- Exit from DONE: E and V fall one edge after B rises or START falls.
- Reset is asynchronous assert, synchronous deassert; all outputs go to reset values immediately.
- KEY_VALID held for several cycles counts as one key per high cycle; debouncing is done upstream.
- No combinational path from inputs to outputs.

## Configuration
- Macro: ATM_PIN_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT and clears on every accepted digit and on entry to COLLECT.
  - When it reaches TIMEOUT_CYCLES, the block goes to CHECK with a forced mismatch.
  - This counts as a failed attempt, including lock at MAX_TRIES.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; COLLECT waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Shared package atm_pkg:
  - state enum pin_state_t
  - constants DIGIT_W=4 and MAX_DIGIT=9
  - the ATM top-level state codes (001 PIN, 010 menu, …) so that the next-state blocks and this block agree.
- One sub-module, atm_pin_shreg: the digit buffer, digit counter and full flag, with shift, clear and compare-against-STORED_PIN.
- The FSM, TRIES counter and timeout counter live in atm_pin_entry.

## Test plan
- STORED_PIN=0x1234, START=1, keys 1,2,3,4 → E=1, V=1, TRIES=0 two edges after the key 4; START=0 → E=0 next edge.
- Keys 1,2,3,5 → E=1, V=0, TRIES=1; repeat two more sessions with wrong PINs → LOCK=1, TRIES=3, E=1, V=0; UNLOCK → LOCK=0, TRIES=0, IDLE.
- Keys 1, 12, 2, 15, 3, 4 → codes 12 and 15 ignored; E=1, V=1.
- Keys 1,2 then B=1 → IDLE, E=0, TRIES unchanged; B=1 coincident with KEY_VALID → key not captured.
- RST_N low mid-COLLECT after 3 digits → all outputs 0 immediately; after release, a full correct entry → V=1.
- With ATM_PIN_TIMEOUT_EN and TIMEOUT_CYCLES=10: one digit, then idle 10 cycles → E=1, V=0, TRIES=1. Without the macro, the same stimulus leaves the block in COLLECT with E=0.
